pixel_readback_fifo_16: RTL and testbench
=========================================

// Module: pixel_readback_fifo_16
// PURPOSE
//  - Read-side pixel buffer for the sharpening datapath: the filter writes 16-bit result pixels, the DLX reads them back.
//  - Buffers up to DEPTH pixels and decouples filter throughput from DLX load timing.
//  - Read data is registered, giving a one-cycle read latency.
//  - Sticky overflow and underflow flags are readable by DLX status logic.
// PARAMETERS
//  - DATA_W  16  pixel width in bits.
//  - ADDR_W  3   pointer width. DEPTH = 2**ADDR_W, so the default depth is 8 entries.
// PORTS
//  - CLK      in   1       clock. All logic is on the rising edge.
//  - RST_N    in   1       synchronous, active-low reset.
//  - WR_EN    in   1       filter write request.
//  - WR_D     in   DATA_W  pixel to write.
//  - FULL     out  1       DEPTH entries are stored.
//  - RD_EN    in   1       DLX read request.
//  - RD_D     out  DATA_W  registered read data.
//  - RD_VALID out  1       RD_D holds a pixel popped on the previous cycle.
//  - EMPTY    out  1       0 entries are stored.
//  - CLR_ERR  in   1       clears OVF and UNF.
//  - OVF      out  1       sticky flag: a write was attempted while full.
//  - UNF      out  1       sticky flag: a read was attempted while empty.
// BEHAVIOUR
//  - Reset: on the CLK edge with RST_N=0, all of the following take the values shown.
//    - wr_ptr=0, rd_ptr=0, count=0.
//    - FULL=0, EMPTY=1, RD_D=0, RD_VALID=0, OVF=0, UNF=0.
//    - Memory contents are not reset.
//    - Reset mid-stream discards all stored pixels, and any read in flight drops RD_VALID.
//  - Write accept: WR_EN & ~FULL. The pixel is stored at wr_ptr and wr_ptr increments.
//  - Read accept: RD_EN & ~EMPTY. RD_D <= mem[rd_ptr], RD_VALID <= 1, rd_ptr increments.
//  - Any cycle with no accepted read: RD_VALID <= 0 and RD_D holds its last value.
//  - Pointers are ADDR_W bits wide and wrap modulo DEPTH with no special case.
//  - count is ADDR_W+1 bits wide.
//    - FULL = (count==DEPTH).
//    - EMPTY = (count==0).
//    - Both flags come straight from the count register, with no combinational path from the input ports.
//  - Simultaneous accepted read and write: count is unchanged. Both pointers advance.
//  - Write while FULL: rejected, even if a read is accepted in the same cycle (no pass-through at full). OVF <= 1.
//  - Read while EMPTY: ignored, even if a write is accepted in the same cycle (no fall-through). UNF <= 1 and RD_VALID <= 0.
//  - Flag priority: CLR_ERR=1 clears OVF and UNF unless a new error occurs in the same cycle. The new error wins and its flag stays 1.
//  - Stored data order is strictly FIFO. A write followed by a read one cycle later returns that pixel.
//  - Latency:
//    - Write to EMPTY deasserting: 1 cycle.
//    - RD_EN to RD_VALID and RD_D: 1 cycle.
// CONFIGURATION
//  - PIXEL_FIFO_LEVEL_EN defined:
//    - Adds output port LEVEL [ADDR_W:0], equal to count (registered, reset 0).
//    - Adds output port ALMOST_FULL, equal to (count >= DEPTH-1) (reset 0).
//  - PIXEL_FIFO_LEVEL_EN undefined:
//    - Neither port exists.
//    - All other behaviour is identical.
// TESTING
//  - All tests use DATA_W=16 and ADDR_W=3.
//  - Reset: hold RST_N=0 for 2 cycles with WR_EN=1 -> EMPTY=1, FULL=0, RD_VALID=0, OVF=0, UNF=0, and no write is accepted.
//  - Fill then drain:
//    - Write 0x0001..0x0008 -> FULL=1 after the 8th write.
//    - Then 8 reads -> RD_D returns 0x0001..0x0008 in order, each one cycle after RD_EN. EMPTY=1 after the last read.
//  - Overflow: at FULL, write 0xBEEF with RD_EN=1 in the same cycle ->
//    - The read returns the oldest pixel.
//    - 0xBEEF is not stored.
//    - OVF=1.
//    - count=7.
//  - Underflow: at EMPTY, RD_EN=1 and WR_EN=1 with 0x1234 ->
//    - UNF=1 and RD_VALID=0.
//    - The next cycle's read returns 0x1234.
//    - CLR_ERR=1 then clears UNF.
//  - Wrap-around: 20 interleaved write/read pairs with data 0x0100+i at occupancy 3 -> all 20 pixels come out in order and FULL never asserts.
//  - Reset mid-stream: with 5 pixels stored, pulse RST_N low for 1 cycle ->
//    - EMPTY=1.
//    - The next read sets UNF=1.
//    - With PIXEL_FIFO_LEVEL_EN: LEVEL=0.

Source files
------------

// File: rtl/pixel_readback_fifo_16.sv
// Read-side pixel FIFO between the sharpening filter and the DLX. Reads have 1-cycle registered latency.
// Backpressure: FULL rejects writes, EMPTY ignores reads, and both raise sticky OVF/UNF. Define PIXEL_FIFO_LEVEL_EN to add the LEVEL and ALMOST_FULL ports.
module pixel_readback_fifo_16 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WR_EN,
  input  logic [DATA_W-1:0] WR_D,
  output logic              FULL,
  input  logic              RD_EN,
  output logic [DATA_W-1:0] RD_D,
  output logic              RD_VALID,
  output logic              EMPTY,
  input  logic              CLR_ERR,
  output logic              OVF,
  output logic              UNF
`ifdef PIXEL_FIFO_LEVEL_EN
  ,
  output logic [ADDR_W:0]   LEVEL,
  output logic              ALMOST_FULL
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ALMOST_LVL = (ADDR_W+1)'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              wr_acc;
  logic              rd_acc;
  logic              wr_err;
  logic              rd_err;

  // Flags come from the count register only, so there is no input-to-flag path.
  assign FULL   = (count == FULL_LVL);
  assign EMPTY  = (count == '0);
  assign wr_acc = WR_EN & ~FULL;
  assign rd_acc = RD_EN & ~EMPTY;
  assign wr_err = WR_EN & FULL;
  assign rd_err = RD_EN & EMPTY;

`ifdef PIXEL_FIFO_LEVEL_EN
  assign LEVEL       = count;
  assign ALMOST_FULL = (count >= ALMOST_LVL);
`endif

  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wr_ptr] <= WR_D;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      RD_D     <= '0;
      RD_VALID <= 1'b0;
      OVF      <= 1'b0;
      UNF      <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        RD_D   <= mem[rd_ptr];
      end
      RD_VALID <= rd_acc;

      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase

      // A fresh error in the same cycle beats CLR_ERR.
      if (wr_err)       OVF <= 1'b1;
      else if (CLR_ERR) OVF <= 1'b0;
      if (rd_err)       UNF <= 1'b1;
      else if (CLR_ERR) UNF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_readback_fifo_16.sv
// Bench for pixel_readback_fifo_16: directed stimulus that queues the expected read data.
// A negedge monitor pops the queue and compares it with each RD_VALID beat.
module tb_pixel_readback_fifo_16;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        WR_EN = 1'b0;
  logic [15:0] WR_D = '0;
  logic        FULL;
  logic        RD_EN = 1'b0;
  logic [15:0] RD_D;
  logic        RD_VALID;
  logic        EMPTY;
  logic        CLR_ERR = 1'b0;
  logic        OVF;
  logic        UNF;
`ifdef PIXEL_FIFO_LEVEL_EN
  logic [3:0]  LEVEL;
  logic        ALMOST_FULL;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  always #5 CLK = ~CLK;

  pixel_readback_fifo_16 #(.DATA_W(16), .ADDR_W(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_D(WR_D), .FULL(FULL),
    .RD_EN(RD_EN), .RD_D(RD_D), .RD_VALID(RD_VALID), .EMPTY(EMPTY),
    .CLR_ERR(CLR_ERR), .OVF(OVF), .UNF(UNF)
`ifdef PIXEL_FIFO_LEVEL_EN
    , .LEVEL(LEVEL), .ALMOST_FULL(ALMOST_FULL)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and return #1 after the sampling edge.
  task automatic cycle(input logic wr, input logic [15:0] d, input logic rd, input logic clr);
    WR_EN = wr; WR_D = d; RD_EN = rd; CLR_ERR = clr;
    @(posedge CLK); #1;
    WR_EN = 1'b0; RD_EN = 1'b0; CLR_ERR = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (RD_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rd: got RD_D=0x%0h with no pixel expected at %0t", RD_D, $time);
      end else begin
        check("rd_d", 32'(RD_D), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for 2 cycles with a write request present.
    RST_N = 1'b0;
    cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
    cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
    check("rst_empty", 32'(EMPTY), 1);
    check("rst_full", 32'(FULL), 0);
    check("rst_rd_valid", 32'(RD_VALID), 0);
    check("rst_rd_d", 32'(RD_D), 0);
    check("rst_ovf", 32'(OVF), 0);
    check("rst_unf", 32'(UNF), 0);
`ifdef PIXEL_FIFO_LEVEL_EN
    check("rst_level", 32'(LEVEL), 0);
    check("rst_almost_full", 32'(ALMOST_FULL), 0);
`endif
    RST_N = 1'b1;
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    check("rst_no_write", 32'(EMPTY), 1);

    // Fill then drain.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 16'(i), 1'b0, 1'b0);
      check("fill_full", 32'(FULL), (i == 8) ? 1 : 0);
      if (i == 1) check("empty_after_write", 32'(EMPTY), 0);
`ifdef PIXEL_FIFO_LEVEL_EN
      check("fill_level", 32'(LEVEL), i);
      check("fill_almost_full", 32'(ALMOST_FULL), (i >= 7) ? 1 : 0);
`endif
    end
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(16'(i));
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      check("drain_rd_valid", 32'(RD_VALID), 1);
    end
    check("drain_empty", 32'(EMPTY), 1);

    // Overflow: a write at full is rejected even though a read is accepted in the same cycle.
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0011 + 16'(i), 1'b0, 1'b0);
    exp_q.push_back(16'h0011);
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
    check("ovf_set", 32'(OVF), 1);
    check("ovf_full_clear", 32'(FULL), 0);
`ifdef PIXEL_FIFO_LEVEL_EN
    check("ovf_level", 32'(LEVEL), 7);
`endif
    for (int i = 1; i < 8; i++) begin
      exp_q.push_back(16'h0011 + 16'(i));
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
    end
    check("ovf_drained_empty", 32'(EMPTY), 1);

    // CLR_ERR together with a new underflow: OVF clears, UNF stays set.
    cycle(1'b0, 16'h0, 1'b1, 1'b1);
    check("clr_ovf", 32'(OVF), 0);
    check("unf_beats_clr", 32'(UNF), 1);
    check("unf_rd_valid", 32'(RD_VALID), 0);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    check("clr_unf", 32'(UNF), 0);

    // Underflow with a write accepted in the same cycle (no fall-through).
    cycle(1'b1, 16'h1234, 1'b1, 1'b0);
    check("unf2_set", 32'(UNF), 1);
    check("unf2_rd_valid", 32'(RD_VALID), 0);
    check("unf2_not_empty", 32'(EMPTY), 0);
    exp_q.push_back(16'h1234);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    check("unf2_read_back", 32'(RD_VALID), 1);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    check("unf2_clr", 32'(UNF), 0);
    check("unf2_empty", 32'(EMPTY), 1);

    // Wrap-around at occupancy 3.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back((i < 3) ? 16'h0200 + 16'(i) : 16'h0100 + 16'(i - 3));
      cycle(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);
      check("wrap_full", 32'(FULL), 0);
    end
    for (int i = 17; i < 20; i++) begin
      exp_q.push_back(16'h0100 + 16'(i));
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
    end
    check("wrap_empty", 32'(EMPTY), 1);
    check("wrap_no_ovf", 32'(OVF), 0);

    // Reset mid-stream with a read in flight and 5 pixels still stored.
    for (int i = 0; i < 6; i++) cycle(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0);
    exp_q.push_back(16'h0300);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    RST_N = 1'b0;
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    RST_N = 1'b1;
    check("mid_rst_empty", 32'(EMPTY), 1);
    check("mid_rst_rd_valid", 32'(RD_VALID), 0);
`ifdef PIXEL_FIFO_LEVEL_EN
    check("mid_rst_level", 32'(LEVEL), 0);
`endif
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    check("mid_rst_unf", 32'(UNF), 1);
    check("mid_rst_no_data", 32'(RD_VALID), 0);

    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
